// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage of the five-stage pipeline.
// Runs a request/ready handshake with the data RAM, steers byte lanes for
// stores, extends load data and presents the write-back tuple used by ID
// forwarding. The pipeline is stalled until the access reaches DONE.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_flag,
  input  logic        mem_write_flag,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign_ext,
  input  logic [31:0] address,
  input  logic [31:0] write_data_in,
  input  logic [31:0] result_in,
  input  logic        reg_write_en_in,
  input  logic [4:0]  reg_write_addr_in,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data,
  input  logic        ram_ready,
  output logic        stall_request,
  output logic        address_error,
  output logic        load_flag,
  output logic        reg_write_en_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] data_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  logic        mem_access;
  logic        misaligned;
  logic        mem_op;
  logic        bus_active;
  logic [1:0]  lane;
  logic [3:0]  strobe;
  logic [31:0] store_data;
  logic [31:0] load_ext;

  assign mem_access = mem_read_flag | mem_write_flag;
  assign lane       = address[1:0];
  // Size 3 behaves as a word, so anything that is not byte or half needs
  // full word alignment.
  assign misaligned = mem_access &
                      (((mem_size == 2'd1) & address[0]) |
                       ((mem_size[1] == 1'b1) & (address[1:0] != 2'b00)));
  assign mem_op     = mem_access & ~misaligned;

  assign ram_addr           = {address[31:2], 2'b00};
  assign load_flag          = mem_read_flag;
  assign reg_write_addr_out = reg_write_addr_in;

  // State and read-data buffer; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rdata_buf_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  // Next state: a ready pulse completes the request either in the request
  // cycle itself or later from WAIT; DONE always lasts exactly one cycle.
  always_comb begin
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          if (ram_ready) begin
            rdata_buf_d = ram_read_data;
            state_d     = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (ram_ready) begin
          rdata_buf_d = ram_read_data;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Store lane steering and load extraction/extension from the buffered word.
  always_comb begin
    strobe     = 4'b1111;
    store_data = write_data_in;
    load_ext   = rdata_buf_q;
    case (mem_size)
      2'd0: begin
        strobe     = 4'b0001 << lane;
        store_data = {4{write_data_in[7:0]}};
        case (lane)
          2'd0:    load_ext = {{24{mem_sign_ext & rdata_buf_q[7]}},  rdata_buf_q[7:0]};
          2'd1:    load_ext = {{24{mem_sign_ext & rdata_buf_q[15]}}, rdata_buf_q[15:8]};
          2'd2:    load_ext = {{24{mem_sign_ext & rdata_buf_q[23]}}, rdata_buf_q[23:16]};
          default: load_ext = {{24{mem_sign_ext & rdata_buf_q[31]}}, rdata_buf_q[31:24]};
        endcase
      end
      2'd1: begin
        strobe     = address[1] ? 4'b1100 : 4'b0011;
        store_data = {2{write_data_in[15:0]}};
        if (address[1]) begin
          load_ext = {{16{mem_sign_ext & rdata_buf_q[31]}}, rdata_buf_q[31:16]};
        end else begin
          load_ext = {{16{mem_sign_ext & rdata_buf_q[15]}}, rdata_buf_q[15:0]};
        end
      end
      default: begin
        strobe     = 4'b1111;
        store_data = write_data_in;
        load_ext   = rdata_buf_q;
      end
    endcase
  end

  // Outputs: the bus is held and the pipeline stalled from the request cycle
  // until ready; write-back of a load is suppressed until its data is in DONE.
  always_comb begin
    bus_active       = ((state_q == S_IDLE) & mem_op) | (state_q == S_WAIT);
    ram_en           = bus_active & ~rst;
    stall_request    = bus_active & ~rst;
    ram_write_en     = (ram_en & mem_write_flag) ? strobe : 4'b0000;
    ram_write_data   = store_data;
    address_error    = misaligned & ~rst;
    reg_write_en_out = reg_write_en_in & ~misaligned & ~rst &
                       ~(mem_read_flag & (state_q != S_DONE));
    data_out         = (mem_read_flag & (state_q == S_DONE)) ? load_ext : result_in;
  end

endmodule
